// File: rtl/byte_receiver.sv
// UART receive path: recovers inverted-line 8N1 frames (idle low, start high, stop low)
// from an oversampled serial input and strobes out each good byte or framing error.
module byte_receiver #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_x_clk,
    input  logic       uart_rx_pin,
    output logic [7:0] received_byte,
    output logic       byte_ready,
    output logic       framing_error,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam logic [CNT_W-1:0] T_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] T_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic                rx_meta, rx_s;
    logic [CNT_W-1:0]    tick_cnt, tick_nxt;
    logic [CNT_W-1:0]    idle_cnt, idle_nxt;
    logic [IDX_W-1:0]    bit_idx, bit_idx_nxt;
    logic [DATA_W-1:0]   shift_reg, shift_nxt;
    logic [DATA_W-1:0]   rbyte_nxt;
    logic                ready_nxt, ferr_nxt;

    // Two-flop synchronizer for the asynchronous line
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= uart_rx_pin;
            rx_s    <= rx_meta;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_IDLE;
            tick_cnt      <= '0;
            idle_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            received_byte <= '0;
            byte_ready    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state         <= state_nxt;
            tick_cnt      <= tick_nxt;
            idle_cnt      <= idle_nxt;
            bit_idx       <= bit_idx_nxt;
            shift_reg     <= shift_nxt;
            received_byte <= rbyte_nxt;
            byte_ready    <= ready_nxt;
            framing_error <= ferr_nxt;
            busy          <= (state_nxt != IDLE);
        end
    end

    // Next-state logic; only baud ticks advance the frame
    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick_cnt;
        idle_nxt    = idle_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        rbyte_nxt   = received_byte;
        ready_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            WAIT_IDLE: begin
                if (baud_x_clk) begin
                    if (rx_s) begin
                        idle_nxt = '0;
                    end else if (idle_cnt == T_FULL) begin
                        idle_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        idle_nxt = idle_cnt + CNT_W'(1);
                    end
                end
            end
            IDLE: begin
                if (baud_x_clk && rx_s) begin
                    tick_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_x_clk) begin
                    if (tick_cnt == T_HALF) begin
                        tick_nxt = '0;
                        if (rx_s) begin
                            bit_idx_nxt = '0;
                            state_nxt   = DATA;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (baud_x_clk) begin
                    if (tick_cnt == T_FULL) begin
                        tick_nxt           = '0;
                        shift_nxt[bit_idx] = rx_s;
                        if (bit_idx == LAST_BIT) begin
                            state_nxt = STOP;
                        end else begin
                            bit_idx_nxt = bit_idx + IDX_W'(1);
                        end
                    end else begin
                        tick_nxt = tick_cnt + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_x_clk) begin
                    if (tick_cnt == T_FULL) begin
                        tick_nxt = '0;
                        if (!rx_s) begin
                            rbyte_nxt = shift_reg;
                            ready_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            idle_nxt  = '0;
                            state_nxt = WAIT_IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                idle_nxt  = '0;
                state_nxt = WAIT_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_byte_receiver.sv
// Scoreboard bench for byte_receiver: a bit-level transmitter model drives the line,
// expected bytes are queued at send time and checked against each byte_ready strobe.
module tb_byte_receiver;

    localparam int unsigned BIT_CLK = 64;

    logic       clk;
    logic       reset;
    logic       baud_x_clk;
    logic       uart_rx_pin;
    logic [7:0] received_byte;
    logic       byte_ready;
    logic       framing_error;
    logic       busy;

    int         n_vec;
    int         n_miss;
    int         ready_cnt;
    int         fe_cnt;
    int         cyc;
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    logic       prev_strobe;
    logic       line;
    logic       rst_q;
    logic       baud_cont;

    byte_receiver dut (
        .clk           (clk),
        .reset         (reset),
        .baud_x_clk    (baud_x_clk),
        .uart_rx_pin   (uart_rx_pin),
        .received_byte (received_byte),
        .byte_ready    (byte_ready),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clk: check strobes from the last rising edge, then drive the next inputs
    task automatic step();
        logic [7:0] exp;
        @(negedge clk);
        if (byte_ready === 1'b1) begin
            ready_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_byte got %h expected no strobe", received_byte);
            end else begin
                exp = exp_q.pop_front();
                if (received_byte !== exp) begin
                    n_miss++;
                    $display("FAIL scoreboard_byte got %h expected %h", received_byte, exp);
                end
            end
        end
        if (framing_error === 1'b1) fe_cnt++;
        if (byte_ready === 1'b1 || framing_error === 1'b1) begin
            n_vec++;
            if (prev_strobe || (byte_ready === 1'b1 && framing_error === 1'b1)) begin
                n_miss++;
                $display("FAIL strobe_overlap got ready=%b ferr=%b prev=%b expected isolated strobe",
                         byte_ready, framing_error, prev_strobe);
            end
        end
        prev_strobe = (byte_ready === 1'b1) || (framing_error === 1'b1);
        cyc++;
        baud_x_clk  = baud_cont ? 1'b1 : ((cyc % 4) == 0);
        uart_rx_pin = line;
        reset       = rst_q;
    endtask

    task automatic hold(input logic v, input int n);
        line = v;
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int period, input logic stop_v);
        if (!stop_v) begin
            exp_q.push_back(b);
            last_good = b;
        end
        hold(1'b1, period);
        for (int i = 0; i < 8; i++) hold(b[i], period);
        hold(stop_v, period);
    endtask

    task automatic test_reset();
        rst_q = 1'b1;
        line  = 1'b0;
        repeat (4) step();
        n_vec++;
        if (received_byte !== 8'h00 || byte_ready !== 1'b0 || framing_error !== 1'b0 || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_values got byte=%h rdy=%b fe=%b busy=%b expected 00 0 0 1",
                     received_byte, byte_ready, framing_error, busy);
        end
        rst_q = 1'b0;
        hold(1'b0, 20 * BIT_CLK);
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++;
            $display("FAIL idle_qualified got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_good_byte();
        int r0, f0;
        r0 = ready_cnt;
        f0 = fe_cnt;
        send_byte(8'hA5, BIT_CLK, 1'b0);
        hold(1'b0, BIT_CLK);
        n_vec++;
        if (ready_cnt - r0 !== 1 || fe_cnt !== f0 || received_byte !== 8'hA5 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL good_byte got rdy=%0d fe=%0d byte=%h busy=%b expected 1 0 a5 0",
                     ready_cnt - r0, fe_cnt - f0, received_byte, busy);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = ready_cnt;
        send_byte(8'h00, BIT_CLK, 1'b0);
        send_byte(8'hFF, BIT_CLK, 1'b0);
        send_byte(8'h3C, BIT_CLK, 1'b0);
        hold(1'b0, BIT_CLK);
        n_vec++;
        if (ready_cnt - r0 !== 3 || received_byte !== 8'h3C) begin
            n_miss++;
            $display("FAIL back_to_back got pulses=%0d byte=%h expected 3 3c", ready_cnt - r0, received_byte);
        end
    endtask

    task automatic test_false_start();
        int r0, f0;
        r0 = ready_cnt;
        f0 = fe_cnt;
        hold(1'b1, 12);
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL false_start_busy got busy=%b expected 1", busy);
        end
        hold(1'b1, 4);
        hold(1'b0, 100);
        n_vec++;
        if (busy !== 1'b0 || ready_cnt !== r0 || fe_cnt !== f0) begin
            n_miss++;
            $display("FAIL false_start got busy=%b rdy=%0d fe=%0d expected 0 0 0",
                     busy, ready_cnt - r0, fe_cnt - f0);
        end
    endtask

    task automatic test_framing_error();
        int r0, f0;
        r0 = ready_cnt;
        f0 = fe_cnt;
        send_byte(8'h5A, BIT_CLK, 1'b1);
        hold(1'b1, 3 * BIT_CLK);
        n_vec++;
        if (fe_cnt - f0 !== 1 || ready_cnt !== r0 || received_byte !== last_good || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL framing_error got fe=%0d rdy=%0d byte=%h busy=%b expected 1 0 %h 1",
                     fe_cnt - f0, ready_cnt - r0, received_byte, busy, last_good);
        end
        hold(1'b0, 40);
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL requalify_early got busy=%b expected 1", busy);
        end
        hold(1'b0, 40);
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++;
            $display("FAIL requalify_done got busy=%b expected 0", busy);
        end
        send_byte(8'h81, BIT_CLK, 1'b0);
        hold(1'b0, BIT_CLK);
        n_vec++;
        if (received_byte !== 8'h81 || fe_cnt - f0 !== 1) begin
            n_miss++;
            $display("FAIL after_ferr got byte=%h fe=%0d expected 81 1", received_byte, fe_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0, f0;
        logic [7:0] b;
        b  = 8'hC3;
        hold(1'b1, BIT_CLK);
        for (int i = 0; i < 3; i++) hold(b[i], BIT_CLK);
        hold(b[3], 20);
        rst_q = 1'b1;
        step();
        rst_q = 1'b0;
        step();
        n_vec++;
        if (received_byte !== 8'h00 || byte_ready !== 1'b0 || framing_error !== 1'b0 || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_mid_frame got byte=%h rdy=%b fe=%b busy=%b expected 00 0 0 1",
                     received_byte, byte_ready, framing_error, busy);
        end
        last_good = 8'h00;
        r0 = ready_cnt;
        f0 = fe_cnt;
        hold(1'b0, 20 * BIT_CLK);
        n_vec++;
        if (busy !== 1'b0 || ready_cnt !== r0 || fe_cnt !== f0) begin
            n_miss++;
            $display("FAIL reset_requalify got busy=%b rdy=%0d fe=%0d expected 0 0 0",
                     busy, ready_cnt - r0, fe_cnt - f0);
        end
        send_byte(8'h42, BIT_CLK, 1'b0);
        hold(1'b0, BIT_CLK);
        n_vec++;
        if (received_byte !== 8'h42 || ready_cnt - r0 !== 1) begin
            n_miss++;
            $display("FAIL post_reset_byte got byte=%h pulses=%0d expected 42 1", received_byte, ready_cnt - r0);
        end
    endtask

    task automatic test_baud_tolerance();
        int r0, f0;
        r0 = ready_cnt;
        f0 = fe_cnt;
        send_byte(8'h96, 61, 1'b0);
        hold(1'b0, 3 * BIT_CLK);
        n_vec++;
        if (received_byte !== 8'h96 || ready_cnt - r0 !== 1 || fe_cnt !== f0) begin
            n_miss++;
            $display("FAIL baud_slow_tx got byte=%h rdy=%0d fe=%0d expected 96 1 0",
                     received_byte, ready_cnt - r0, fe_cnt - f0);
        end
        send_byte(8'h96, 67, 1'b0);
        hold(1'b0, 3 * BIT_CLK);
        n_vec++;
        if (received_byte !== 8'h96 || ready_cnt - r0 !== 2 || fe_cnt !== f0) begin
            n_miss++;
            $display("FAIL baud_fast_tx got byte=%h rdy=%0d fe=%0d expected 96 2 0",
                     received_byte, ready_cnt - r0, fe_cnt - f0);
        end
    endtask

    task automatic test_continuous_tick();
        int r0;
        r0 = ready_cnt;
        baud_cont = 1'b1;
        hold(1'b0, 32);
        send_byte(8'hE7, 16, 1'b0);
        send_byte(8'h18, 16, 1'b0);
        hold(1'b0, 32);
        baud_cont = 1'b0;
        n_vec++;
        if (received_byte !== 8'h18 || ready_cnt - r0 !== 2) begin
            n_miss++;
            $display("FAIL continuous_tick got byte=%h pulses=%0d expected 18 2", received_byte, ready_cnt - r0);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        ready_cnt   = 0;
        fe_cnt      = 0;
        cyc         = 0;
        last_good   = 8'h00;
        prev_strobe = 1'b0;
        line        = 1'b0;
        rst_q       = 1'b1;
        baud_cont   = 1'b0;
        reset       = 1'b1;
        baud_x_clk  = 1'b0;
        uart_rx_pin = 1'b0;

        test_reset();
        test_good_byte();
        test_back_to_back();
        test_false_start();
        test_framing_error();
        test_reset_mid_frame();
        test_baud_tolerance();
        test_continuous_tick();

        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
